mips_mul_div_unit: RTL and testbench

- Execute-stage HI/LO unit for the pipelined MIPS core. It consumes instructions that the categorizer has flagged as mulDiv or hilo.
- Runs MULT/MULTU/DIV/DIVU iteratively, one bit per cycle, and owns the HI/LO registers.
- Serves MFHI/MFLO/MTHI/MTLO and raises a stall to the hazard logic while an operation is in flight.

---
 rtl/mips_mul_div_pkg.sv | 25 ++
 rtl/mips_mul_div_step.sv | 41 ++++
 rtl/mips_mul_div_unit.sv | 135 +++++++++++++
 tb/tb_mips_mul_div_unit.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/mips_mul_div_pkg.sv
// Shared definitions for the MIPS HI/LO multiply/divide unit:
// func-field codes, FSM states and the iteration counter sizing.
package mips_mul_div_pkg;

    localparam logic [5:0] FUNC_MFHI  = 6'b010000;
    localparam logic [5:0] FUNC_MTHI  = 6'b010001;
    localparam logic [5:0] FUNC_MFLO  = 6'b010010;
    localparam logic [5:0] FUNC_MTLO  = 6'b010011;
    localparam logic [5:0] FUNC_MULT  = 6'b011000;
    localparam logic [5:0] FUNC_MULTU = 6'b011001;
    localparam logic [5:0] FUNC_DIV   = 6'b011010;
    localparam logic [5:0] FUNC_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    // Counter must hold the value WIDTH itself, hence the extra bit.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/mips_mul_div_step.sv
// One iteration of the multiply/divide datapath: a shift-add multiply step
// or a restoring-divide step on the {acc, shift} register pair.
module mips_mul_div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             isDiv,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] shift,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] shift_next
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] partial;
    logic [WIDTH:0] rem_shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        sum         = {1'b0, acc} + {1'b0, operand};
        partial     = shift[0] ? sum : {1'b0, acc};
        rem_shifted = {acc, shift[WIDTH-1]};
        diff        = rem_shifted - {1'b0, operand};
        acc_next    = acc;
        shift_next  = shift;
        if (isDiv) begin
            // Partial remainder stays below the divisor, so a set MSB in diff is a borrow.
            if (!diff[WIDTH]) begin
                acc_next   = diff[WIDTH-1:0];
                shift_next = {shift[WIDTH-2:0], 1'b1};
            end else begin
                acc_next   = rem_shifted[WIDTH-1:0];
                shift_next = {shift[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_next   = partial[WIDTH:1];
            shift_next = {partial[0], shift[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mips_mul_div_unit.sv
// Execute-stage HI/LO unit: iterative MULT/MULTU/DIV/DIVU plus MFHI/MFLO/MTHI/MTLO,
// stalling the pipeline while an operation is in flight.
module mips_mul_div_unit
    import mips_mul_div_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             resetN,
    input  logic             opValid,
    input  logic [5:0]       opFunc,
    input  logic [WIDTH-1:0] rsValue,
    input  logic [WIDTH-1:0] rtValue,
    output logic             stall,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] readValue
);

    localparam int unsigned CW = cnt_width(WIDTH);

    state_t            state, state_next;
    logic [CW-1:0]     counter;
    logic [WIDTH-1:0]  acc, shift, operand;
    logic [WIDTH-1:0]  acc_next, shift_next;
    logic              is_div, div_zero, neg_result, neg_rem;

    logic              accept, op_start, op_signed, op_div, start_div_zero;
    logic [WIDTH-1:0]  rs_mag, rt_mag;
    logic [2*WIDTH-1:0] product;

    always_comb begin
        accept         = opValid && (state == IDLE);
        op_start       = accept && (opFunc == FUNC_MULT || opFunc == FUNC_MULTU ||
                                    opFunc == FUNC_DIV  || opFunc == FUNC_DIVU);
        op_signed      = (opFunc == FUNC_MULT) || (opFunc == FUNC_DIV);
        op_div         = (opFunc == FUNC_DIV)  || (opFunc == FUNC_DIVU);
        start_div_zero = op_start && op_div && (rtValue == '0);
        rs_mag         = (op_signed && rsValue[WIDTH-1]) ? -rsValue : rsValue;
        rt_mag         = (op_signed && rtValue[WIDTH-1]) ? -rtValue : rtValue;
        product        = neg_result ? -{acc, shift} : {acc, shift};
    end

    mips_mul_div_step #(.WIDTH(WIDTH)) u_step (
        .isDiv      (is_div),
        .acc        (acc),
        .shift      (shift),
        .operand    (operand),
        .acc_next   (acc_next),
        .shift_next (shift_next)
    );

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (op_start) state_next = start_div_zero ? FIX : RUN;
            RUN:  if (counter == CW'(1)) state_next = FIX;
            FIX:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            counter    <= '0;
            acc        <= '0;
            shift      <= '0;
            operand    <= '0;
            is_div     <= 1'b0;
            div_zero   <= 1'b0;
            neg_result <= 1'b0;
            neg_rem    <= 1'b0;
            hi         <= '0;
            lo         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && opFunc == FUNC_MTHI) hi <= rsValue;
                    if (accept && opFunc == FUNC_MTLO) lo <= rsValue;
                    if (op_start) begin
                        counter <= CW'(WIDTH);
                        is_div  <= op_div;
                        operand <= rt_mag;
                        if (start_div_zero) begin
                            // Divide by zero: raw dividend as remainder, all-ones quotient.
                            acc        <= rsValue;
                            shift      <= '1;
                            div_zero   <= 1'b1;
                            neg_result <= 1'b0;
                            neg_rem    <= 1'b0;
                        end else begin
                            acc        <= '0;
                            shift      <= rs_mag;
                            div_zero   <= 1'b0;
                            neg_result <= op_signed && (rsValue[WIDTH-1] ^ rtValue[WIDTH-1]);
                            neg_rem    <= op_signed && rsValue[WIDTH-1];
                        end
                    end
                end
                RUN: begin
                    acc     <= acc_next;
                    shift   <= shift_next;
                    counter <= counter - CW'(1);
                end
                FIX: begin
                    if (!is_div) begin
                        {hi, lo} <= product;
                    end else if (div_zero) begin
                        hi <= acc;
                        lo <= shift;
                    end else begin
                        hi <= neg_rem    ? -acc   : acc;
                        lo <= neg_result ? -shift : shift;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy      = (state != IDLE);
        stall     = opValid && busy;
        readValue = '0;
        if (accept && opFunc == FUNC_MFHI) readValue = hi;
        if (accept && opFunc == FUNC_MFLO) readValue = lo;
    end

endmodule

// File: tb/tb_mips_mul_div_unit.sv
// Directed, table-driven bench for the HI/LO multiply/divide unit.
module tb_mips_mul_div_unit;

    logic        clock;
    logic        resetN;
    logic        opValid;
    logic [5:0]  opFunc;
    logic [31:0] rsValue, rtValue;
    logic        stall, busy;
    logic [31:0] hi, lo, readValue;

    int n_checks = 0;
    int n_fail   = 0;

    mips_mul_div_unit #(.WIDTH(32)) dut (
        .clock     (clock),
        .resetN    (resetN),
        .opValid   (opValid),
        .opFunc    (opFunc),
        .rsValue   (rsValue),
        .rtValue   (rtValue),
        .stall     (stall),
        .busy      (busy),
        .hi        (hi),
        .lo        (lo),
        .readValue (readValue)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [5:0]  func;
        logic [31:0] rs;
        logic [31:0] rt;
        int          cycles;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Presents one op on the negedge; returns #1 after the edge that accepts it.
    task automatic issue(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt);
        @(negedge clock);
        opValid = 1'b1; opFunc = f; rsValue = rs; rtValue = rt;
        @(posedge clock); #1;
        opValid = 1'b0;
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (busy && cycles < 200) begin
            @(posedge clock); #1;
            cycles++;
        end
    endtask

    logic [31:0] exp_hi, exp_lo;
    int          cyc;

    initial begin
        opValid = 1'b0; opFunc = '0; rsValue = '0; rtValue = '0;
        resetN = 1'b0;
        repeat (2) @(negedge clock);
        chk("reset hi", hi, 32'h0);
        chk("reset lo", lo, 32'h0);
        chk("reset busy", {31'b0, busy}, 32'h0);
        chk("reset stall", {31'b0, stall}, 32'h0);
        chk("reset readValue", readValue, 32'h0);
        resetN = 1'b1;

        // MTHI then MFHI while idle; MTLO then MFLO.
        issue(6'b010001, 32'h0000_1234, 32'h0);
        chk("mthi hi", hi, 32'h0000_1234);
        chk("mthi busy", {31'b0, busy}, 32'h0);
        @(negedge clock);
        opValid = 1'b1; opFunc = 6'b010000;
        #1;
        chk("mfhi readValue", readValue, 32'h0000_1234);
        chk("mfhi stall", {31'b0, stall}, 32'h0);
        @(posedge clock); #1; opValid = 1'b0;
        chk("mfhi no state change", {31'b0, busy}, 32'h0);
        issue(6'b010011, 32'hCAFE_0001, 32'h0);
        chk("mtlo lo", lo, 32'hCAFE_0001);
        @(negedge clock);
        opValid = 1'b1; opFunc = 6'b010010;
        #1;
        chk("mflo readValue", readValue, 32'hCAFE_0001);
        @(posedge clock); #1; opValid = 1'b0;

        // Unrelated func code is ignored.
        @(negedge clock);
        opValid = 1'b1; opFunc = 6'b100000; rsValue = 32'h5555_5555; rtValue = 32'h3;
        #1;
        chk("ignored readValue", readValue, 32'h0);
        chk("ignored stall", {31'b0, stall}, 32'h0);
        @(posedge clock); #1; opValid = 1'b0;
        chk("ignored busy", {31'b0, busy}, 32'h0);
        chk("ignored hi", hi, 32'h0000_1234);
        chk("ignored lo", lo, 32'hCAFE_0001);

        vecs[0]  = '{6'b011001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[1]  = '{6'b011000, 32'hFFFF_FFFD, 32'h0000_0005, 33, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
        vecs[2]  = '{6'b011010, 32'hFFFF_FFF9, 32'h0000_0002, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3]  = '{6'b011011, 32'd100,       32'd7,         33, 32'h0000_0002, 32'h0000_000E};
        vecs[4]  = '{6'b011010, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0000_0000, 32'h8000_0000};
        vecs[5]  = '{6'b011011, 32'd5,         32'd0,         1,  32'h0000_0005, 32'hFFFF_FFFF};
        vecs[6]  = '{6'b011010, 32'hFFFF_FFFB, 32'd0,         1,  32'hFFFF_FFFB, 32'hFFFF_FFFF};
        vecs[7]  = '{6'b011000, 32'd7,         32'hFFFF_FFFA, 33, 32'hFFFF_FFFF, 32'hFFFF_FFD6};
        vecs[8]  = '{6'b011000, 32'hFFFF_FFFC, 32'hFFFF_FFF8, 33, 32'h0000_0000, 32'h0000_0020};
        vecs[9]  = '{6'b011010, 32'd7,         32'hFFFF_FFFE, 33, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[10] = '{6'b011000, 32'h8000_0000, 32'h8000_0000, 33, 32'h4000_0000, 32'h0000_0000};
        vecs[11] = '{6'b011001, 32'h1234_5678, 32'h0000_0010, 33, 32'h0000_0001, 32'h2345_6780};
        vecs[12] = '{6'b011011, 32'hFFFF_FFFF, 32'h0000_0010, 33, 32'h0000_000F, 32'h0FFF_FFFF};

        exp_hi = 32'h0000_1234;
        exp_lo = 32'hCAFE_0001;
        foreach (vecs[i]) begin
            issue(vecs[i].func, vecs[i].rs, vecs[i].rt);
            chk($sformatf("v%0d hold hi", i), hi, exp_hi);
            chk($sformatf("v%0d hold lo", i), lo, exp_lo);
            wait_idle(cyc);
            chk($sformatf("v%0d busy cycles", i), cyc, vecs[i].cycles);
            chk($sformatf("v%0d hi", i), hi, vecs[i].exp_hi);
            chk($sformatf("v%0d lo", i), lo, vecs[i].exp_lo);
            exp_hi = vecs[i].exp_hi;
            exp_lo = vecs[i].exp_lo;
        end

        // MFLO presented right behind a MULT stalls until the result is written.
        issue(6'b011000, 32'd3, 32'd4);
        opValid = 1'b1; opFunc = 6'b010010;
        cyc = 0;
        while (stall && cyc < 200) begin
            @(posedge clock); #1;
            cyc++;
        end
        chk("mflo stall cycles", cyc, 33);
        chk("mflo after stall", readValue, 32'd12);
        @(posedge clock); #1; opValid = 1'b0;
        chk("mflo busy after accept", {31'b0, busy}, 32'h0);

        // Asynchronous reset in the middle of a divide.
        issue(6'b011011, 32'd1000, 32'd3);
        repeat (9) begin @(posedge clock); #1; end
        chk("pre-reset busy", {31'b0, busy}, 32'h1);
        resetN = 1'b0;
        #1;
        chk("abort hi", hi, 32'h0);
        chk("abort lo", lo, 32'h0);
        chk("abort busy", {31'b0, busy}, 32'h0);
        @(negedge clock);
        resetN = 1'b1;
        issue(6'b011001, 32'd6, 32'd7);
        wait_idle(cyc);
        chk("post-reset cycles", cyc, 33);
        chk("post-reset hi", hi, 32'h0);
        chk("post-reset lo", lo, 32'd42);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
